// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver.
// Circular store with first-word-fall-through read port and sticky overflow.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_RX_DV,
  input  logic [DATA_WIDTH-1:0] i_RX_Byte,
  input  logic                  i_Clear,
  input  logic                  i_Rd_Ready,
  output logic                  o_Rd_Valid,
  output logic [DATA_WIDTH-1:0] o_Rd_Data,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic                  o_Overflow,
  input  logic                  i_Overflow_Clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] r_Mem [DEPTH];
  logic [DEPTH_LOG2:0]   r_Wr_Ptr;
  logic [DEPTH_LOG2:0]   r_Rd_Ptr;
  logic                  r_Overflow;

  logic [DEPTH_LOG2-1:0] w_Wr_Addr;
  logic [DEPTH_LOG2-1:0] w_Rd_Addr;
  logic                  w_Wrap_Diff;
  logic                  w_Full;
  logic                  w_Empty;
  logic                  w_Rd_Fire;
  logic                  w_Wr_Fire;
  logic                  w_Ovf_Set;

  assign w_Wr_Addr   = r_Wr_Ptr[DEPTH_LOG2-1:0];
  assign w_Rd_Addr   = r_Rd_Ptr[DEPTH_LOG2-1:0];
  assign w_Wrap_Diff = r_Wr_Ptr[DEPTH_LOG2] ^ r_Rd_Ptr[DEPTH_LOG2];
  assign w_Full      = w_Wrap_Diff && (w_Wr_Addr == w_Rd_Addr);
  assign w_Empty     = (r_Wr_Ptr == r_Rd_Ptr);

  // A read frees a slot this edge, so a write to a full buffer still fits.
  assign w_Rd_Fire = !w_Empty && i_Rd_Ready;
  assign w_Wr_Fire = i_RX_DV && (!w_Full || w_Rd_Fire);
  assign w_Ovf_Set = i_RX_DV && w_Full && !w_Rd_Fire;

  always_ff @(posedge i_Clk) begin
    if (w_Wr_Fire && !i_Clear) begin
      r_Mem[w_Wr_Addr] <= i_RX_Byte;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
    end else if (i_Clear) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
    end else begin
      if (w_Wr_Fire) begin
        r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
      end
      if (w_Rd_Fire) begin
        r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      end
    end
  end

  // Set beats clear so a coincident drop is never lost.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Overflow <= 1'b0;
    end else if (i_Clear) begin
      r_Overflow <= 1'b0;
    end else if (w_Ovf_Set) begin
      r_Overflow <= 1'b1;
    end else if (i_Overflow_Clr) begin
      r_Overflow <= 1'b0;
    end
  end

  assign o_Rd_Data  = r_Mem[w_Rd_Addr];
  assign o_Rd_Valid = !w_Empty;
  assign o_Empty    = w_Empty;
  assign o_Full     = w_Full;
  assign o_Count    = r_Wr_Ptr - r_Rd_Ptr;
  assign o_Overflow = r_Overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table plus
// queue-modelled sequences for full, wrap, clear and reset cases.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic       dv;
  logic [7:0] rx_byte;
  logic       clr;
  logic       rdy;
  logic       oclr;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       ovf;

  int n_chk;
  int n_err;

  uart_rx_fifo #(
    .DATA_WIDTH(8),
    .DEPTH_LOG2(4)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_RX_DV       (dv),
    .i_RX_Byte     (rx_byte),
    .i_Clear       (clr),
    .i_Rd_Ready    (rdy),
    .o_Rd_Valid    (rd_valid),
    .o_Rd_Data     (rd_data),
    .o_Count       (count),
    .o_Full        (full),
    .o_Empty       (empty),
    .o_Overflow    (ovf),
    .i_Overflow_Clr(oclr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idle;
    logic       dv;
    logic [7:0] b;
    logic       rdy;
    logic       clr;
    logic       oclr;
    int         cnt;
    logic       ovf;
    logic       chk_d;
    logic [7:0] d;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] m_q[$];
  logic       m_ovf;

  function automatic vec_t mv(int idle, logic v_dv, logic [7:0] v_b,
                              logic v_rdy, int cnt, logic v_ovf,
                              logic cd, logic [7:0] d);
    vec_t v;
    v.idle  = idle;
    v.dv    = v_dv;
    v.b     = v_b;
    v.rdy   = v_rdy;
    v.clr   = 1'b0;
    v.oclr  = 1'b0;
    v.cnt   = cnt;
    v.ovf   = v_ovf;
    v.chk_d = cd;
    v.d     = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic s_dv, input logic [7:0] s_b,
                      input logic s_rdy, input logic s_clr,
                      input logic s_oclr);
    dv      = s_dv;
    rx_byte = s_b;
    rdy     = s_rdy;
    clr     = s_clr;
    oclr    = s_oclr;
    @(posedge clk);
    #1;
    dv      = 1'b0;
    rx_byte = 8'h00;
    rdy     = 1'b0;
    clr     = 1'b0;
    oclr    = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input int cnt, input logic e_ovf);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    chk({tag, ".full"},  32'(full),  32'(cnt == 16));
    chk({tag, ".valid"}, 32'(rd_valid), 32'(cnt != 0));
    chk({tag, ".ovf"},   32'(ovf), 32'(e_ovf));
  endtask

  // Behavioural queue model: step DUT and model together, then compare.
  task automatic mstep(input string tag, input logic s_dv,
                       input logic [7:0] s_b, input logic s_rdy,
                       input logic s_clr, input logic s_oclr);
    logic rd_f;
    logic full_m;
    rd_f   = (m_q.size() > 0) && s_rdy;
    full_m = (m_q.size() == 16);
    if (s_clr) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (s_dv && full_m && !rd_f) m_ovf = 1'b1;
      else if (s_oclr) m_ovf = 1'b0;
      if (rd_f) void'(m_q.pop_front());
      if (s_dv && (!full_m || rd_f)) m_q.push_back(s_b);
    end
    step(s_dv, s_b, s_rdy, s_clr, s_oclr);
    chk_flags(tag, m_q.size(), m_ovf);
    if (m_q.size() > 0) chk({tag, ".data"}, 32'(rd_data), 32'(m_q[0]));
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rst     = 1'b1;
    dv      = 1'b0;
    rx_byte = 8'h00;
    clr     = 1'b0;
    rdy     = 1'b0;
    oclr    = 1'b0;
    m_ovf   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    vecs.push_back(mv(0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mv(0, 0, 8'h00, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mv(868, 1, 8'hA5, 0, 1, 0, 1, 8'hA5));
    vecs.push_back(mv(868, 1, 8'h3C, 0, 2, 0, 1, 8'hA5));
    vecs.push_back(mv(868, 1, 8'h7E, 0, 3, 0, 1, 8'hA5));
    vecs.push_back(mv(0, 0, 8'h00, 1, 2, 0, 1, 8'h3C));
    vecs.push_back(mv(0, 0, 8'h00, 1, 1, 0, 1, 8'h7E));
    vecs.push_back(mv(0, 0, 8'h00, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mv(0, 0, 8'h00, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mv(0, 1, 8'h11, 1, 1, 0, 1, 8'h11));
    vecs.push_back(mv(0, 1, 8'h22, 1, 1, 0, 1, 8'h22));
    vecs.push_back(mv(0, 1, 8'h33, 0, 2, 0, 1, 8'h22));
    vecs.push_back(mv(0, 1, 8'h44, 1, 2, 0, 1, 8'h33));
    vecs.push_back(mv(0, 0, 8'h00, 1, 1, 0, 1, 8'h44));
    vecs.push_back(mv(0, 0, 8'h00, 1, 0, 0, 0, 8'h00));

    foreach (vecs[k]) begin
      repeat (vecs[k].idle) step(0, 8'h00, 0, 0, 0);
      step(vecs[k].dv, vecs[k].b, vecs[k].rdy, vecs[k].clr, vecs[k].oclr);
      chk_flags($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].ovf);
      if (vecs[k].chk_d)
        chk($sformatf("vec%0d.data", k), 32'(rd_data), 32'(vecs[k].d));
    end

    // Fill to full, overflow with 0xFF, drain in order.
    for (int i = 0; i < 16; i++) mstep("fill", 1, 8'(i), 0, 0, 0);
    chk("fill.full16", 32'(full), 32'd1);
    mstep("ovf_ff", 1, 8'hFF, 0, 0, 0);
    chk("ovf_ff.flag", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain.head", 32'(rd_data), 32'(i));
      mstep("drain", 0, 8'h00, 1, 0, 0);
    end
    chk("drain.empty", 32'(empty), 32'd1);

    // Overflow clear alone, then clear coinciding with new drop.
    mstep("oclr", 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 16; i++) mstep("refill", 1, 8'(8'h80 + i), 0, 0, 0);
    mstep("set_vs_clr", 1, 8'hEE, 0, 0, 1);
    chk("set_vs_clr.flag", 32'(ovf), 32'd1);
    mstep("oclr2", 0, 8'h00, 0, 0, 1);

    // Full with simultaneous read+write: no overflow, wraps pointers.
    mstep("full_rw55", 1, 8'h55, 1, 0, 0);
    for (int j = 0; j < 40; j++)
      mstep("wrap_rw", 1, 8'(8'h40 + j), 1, 0, 0);
    for (int i = 0; i < 16; i++) mstep("wrap_drain", 0, 8'h00, 1, 0, 0);

    // Simultaneous write+read with 0x55 arriving into a full buffer, then
    // checked as the final byte of the drain.
    for (int i = 0; i < 16; i++) mstep("fill3", 1, 8'(8'hC0 + i), 0, 0, 0);
    mstep("rw55b", 1, 8'h55, 1, 0, 0);
    for (int i = 0; i < 15; i++) mstep("drain3", 0, 8'h00, 1, 0, 0);
    chk("last55", 32'(rd_data), 32'h55);
    mstep("drain3_end", 0, 8'h00, 1, 0, 0);

    // Clear with 5 stored and a coincident write.
    for (int i = 0; i < 16; i++) mstep("fill4", 1, 8'(i + 1), 0, 0, 0);
    mstep("ovf4", 1, 8'hAA, 0, 0, 0);
    for (int i = 0; i < 11; i++) mstep("down5", 0, 8'h00, 1, 0, 0);
    chk("five.count", 32'(count), 32'd5);
    mstep("clear99", 1, 8'h99, 0, 1, 0);
    mstep("after_clear", 0, 8'h00, 1, 0, 0);
    mstep("post_clear_wr", 1, 8'h12, 0, 0, 0);
    mstep("post_clear_rd", 0, 8'h00, 1, 0, 0);

    // Asynchronous reset mid-fill.
    for (int i = 0; i < 3; i++) mstep("prefill", 1, 8'(8'h60 + i), 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("async_rst.empty", 32'(empty), 32'd1);
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.valid", 32'(rd_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    mstep("post_rst_wr", 1, 8'h77, 0, 0, 0);
    mstep("post_rst_rd", 0, 8'h00, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle data-valid pulse and stores it in a circular buffer.
- Presents the stored bytes to consumer logic (7-segment driver, transmitter echo path) through a first-word-fall-through valid/ready read port.
- Reports occupancy, full/empty and a sticky overflow flag.

Parameters:
- DATA_WIDTH, 8: width of one stored byte.
- DEPTH_LOG2, 4: log2 of buffer depth. Default depth is 16 entries. Legal range is 1..8.

Ports:
- i_Clk  input  1  system clock (100 MHz in the top level).
- i_Rst  input  1  reset, asynchronous, active-high.
- i_RX_DV  input  1  write strobe. One-cycle pulse from the UART receiver's data-valid output.
- i_RX_Byte  input  DATA_WIDTH  byte to store. Sampled only when i_RX_DV=1.
- i_Clear  input  1  synchronous flush of all contents.
- i_Rd_Ready  input  1  consumer accepts the head byte this cycle.
- o_Rd_Valid  output  1  head byte available. Equals NOT o_Empty.
- o_Rd_Data  output  DATA_WIDTH  head byte. Meaningful only when o_Rd_Valid=1.
- o_Count  output  DEPTH_LOG2+1  number of stored bytes, 0..2^DEPTH_LOG2.
- o_Full  output  1  o_Count == 2^DEPTH_LOG2.
- o_Empty  output  1  o_Count == 0.
- o_Overflow  output  1  sticky flag: at least one byte has been dropped.
- i_Overflow_Clr  input  1  clears o_Overflow.

Behaviour:
- Reset (i_Rst=1, asynchronous): write and read pointers go to 0 and o_Overflow goes to 0. Outputs are then o_Count=0, o_Empty=1, o_Full=0, o_Rd_Valid=0.
  - Storage contents are not reset.
  - o_Rd_Data is undefined while empty.
- Pointers:
  - Write and read pointers are each DEPTH_LOG2+1 bits wide. The low DEPTH_LOG2 bits address storage; the MSB is the wrap bit.
  - Both increment modulo 2^(DEPTH_LOG2+1).
  - o_Count = wr_ptr - rd_ptr, computed modulo 2^(DEPTH_LOG2+1).
  - Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal.
- Write: accepted on a rising edge when i_RX_DV=1 and either (not full) or (full and a read fires the same cycle).
  - Storage[wr_ptr] <= i_RX_Byte, and wr_ptr increments.
- Read fires when o_Rd_Valid=1 and i_Rd_Ready=1. rd_ptr increments on that edge.
  - i_Rd_Ready while empty has no effect.
- Latency: a byte written at edge N appears on o_Rd_Data, with o_Rd_Valid=1, immediately after edge N. This is first-word-fall-through.
  - o_Rd_Data is a combinational read of storage[rd_ptr].
- Simultaneous write and read:
  - Not empty: both occur, o_Count unchanged. This includes the full case, where no overflow occurs.
  - Empty: the read is ignored and the write is accepted, so o_Count becomes 1.
- Overflow: i_RX_DV=1 while full with no read firing.
  - The byte is dropped and pointers are unchanged.
  - o_Overflow <= 1 on that edge.
- o_Overflow clearing:
  - Cleared by i_Overflow_Clr=1.
  - If a set event and i_Overflow_Clr coincide, the set wins and the flag stays 1.
- i_Clear=1: on the edge, both pointers go to 0 and o_Overflow goes to 0.
  - Overrides any write, read or overflow event in the same cycle; the same-cycle write is discarded.
- Ordering assumption: i_RX_DV pulses are at least one bit-period apart (868 clocks at 115200 baud). The block nevertheless handles back-to-back pulses every cycle correctly.
- Reset asserted mid-stream: contents are lost immediately and asynchronously. After release, the first i_RX_DV is stored at address 0.
- No combinational path from i_RX_DV or i_RX_Byte to any output other than through registers. o_Rd_Valid, o_Full, o_Empty and o_Count derive from registered pointers only.

Test Plan:
- Reset then idle, no strobes → o_Empty=1, o_Rd_Valid=0, o_Count=0, o_Overflow=0. Then assert i_Rd_Ready for 10 cycles → no pointer change.
- Write 0xA5, 0x3C, 0x7E (i_RX_DV pulses 868 cycles apart, i_Rd_Ready=0) → o_Count=3. Then hold i_Rd_Ready=1 → o_Rd_Data reads 0xA5, 0x3C, 0x7E on consecutive cycles, then o_Empty=1.
- Write 16 bytes 0x00..0x0F → o_Full=1, o_Count=16. A 17th write of 0xFF → o_Overflow=1 and o_Count stays 16. Read out → exactly 0x00..0x0F, with no 0xFF.
- While full, pulse i_RX_DV=0x55 with i_Rd_Ready=1 in the same cycle → o_Count stays 16, o_Overflow stays 0, and 0x55 is read last. Repeat across more than 32 writes to exercise pointer wrap.
- With o_Overflow=1, assert i_Overflow_Clr alone → flag clears. Coincide i_Overflow_Clr with a new overflow → flag remains 1.
- With 5 bytes stored, assert i_Clear together with i_RX_DV=0x99 → o_Count=0 and o_Overflow=0 next cycle, and 0x99 is not stored. Separately, assert i_Rst mid-fill → o_Empty=1 immediately, without waiting for a clock edge.
